cve2_hpm_unit: RTL and testbench

CVE2_HPM_UNIT -- requirements
Module: cve2_hpm_unit

---
 rtl/cve2_pkg.sv | 37 +++
 rtl/cve2_counter.sv | 31 +++
 rtl/cve2_hpm_unit.sv | 140 ++++++++++++++
 tb/tb_cve2_hpm_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cve2_pkg.sv
// Shared CSR encodings and counter constants for the cve2 performance-monitor slice.
package cve2_pkg;

    typedef enum logic [1:0] {
        CSR_OP_READ  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    typedef enum logic [11:0] {
        CSR_MCOUNTINHIBIT  = 12'h320,
        CSR_MHPMEVENT3     = 12'h323,
        CSR_MHPMEVENT4     = 12'h324,
        CSR_MHPMEVENT12    = 12'h32C,
        CSR_MCYCLE         = 12'hB00,
        CSR_MINSTRET       = 12'hB02,
        CSR_MHPMCOUNTER3   = 12'hB03,
        CSR_MHPMCOUNTER4   = 12'hB04,
        CSR_MHPMCOUNTER12  = 12'hB0C,
        CSR_MCYCLEH        = 12'hB80,
        CSR_MINSTRETH      = 12'hB82,
        CSR_MHPMCOUNTER3H  = 12'hB83,
        CSR_MHPMCOUNTER4H  = 12'hB84,
        CSR_MHPMCOUNTER12H = 12'hB8C,
        CSR_CYCLE          = 12'hC00,
        CSR_INSTRET        = 12'hC02,
        CSR_CYCLEH         = 12'hC80,
        CSR_INSTRETH       = 12'hC82
    } csr_num_e;

    localparam int unsigned CSR_MCOUNTINHIBIT_CY_BIT = 0;
    localparam int unsigned CSR_MCOUNTINHIBIT_IR_BIT = 2;
    localparam int unsigned HPM_FIRST_IDX            = 3;
    localparam int unsigned MHPM_MAX_NUM             = 10;

endpackage

// File: rtl/cve2_counter.sv
// Single performance counter: 32-bit half writes, wrap-around increment, writes win over increment.
module cve2_counter #(
    parameter int unsigned CounterWidth = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    incr,
    input  logic                    we_lo,
    input  logic                    we_hi,
    input  logic [CounterWidth-1:0] wdata,
    output logic [CounterWidth-1:0] value
);

    logic [CounterWidth-1:0] value_d;
    logic [CounterWidth-1:0] value_q;

    always_comb begin
        value_d = value_q;
        if (we_lo) value_d[31:0] = wdata[31:0];
        if (we_hi) value_d[CounterWidth-1:32] = wdata[CounterWidth-1:32];
        if (!we_lo && !we_hi && incr) value_d = value_q + CounterWidth'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) value_q <= '0;
        else         value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/cve2_hpm_unit.sv
// Machine cycle/instret/HPM counters, event selectors and mcountinhibit with CSR access.
// Optional CVE2_HPM_USER_ALIAS_EN: read-only user aliases CYCLE(H)/INSTRET(H).
module cve2_hpm_unit import cve2_pkg::*; #(
    parameter int unsigned MHPMCounterNum   = 2,
    parameter int unsigned MHPMCounterWidth = 40,
    parameter int unsigned EventWidth       = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  instr_ret_i,
    input  logic [EventWidth-1:0] hpm_event_i,
    input  logic                  csr_access_i,
    input  csr_num_e              csr_addr_i,
    input  csr_op_e               csr_op_i,
    input  logic [31:0]           csr_wdata_i,
    output logic [31:0]           csr_rdata_o,
    output logic                  csr_hit_o,
    output logic                  csr_illegal_o
);

    localparam logic [31:0] InhibitMask = 32'h5 |
        (((32'd1 << MHPMCounterNum) - 32'd1) << HPM_FIRST_IDX);

    logic [11:0] addr;
    logic [4:0]  sub;
    logic        sub_hpm;
    logic        sub_cnt;
    logic [3:0]  hpm_idx;
    logic        inh_sel, ev_sel, lo_sel, hi_sel;
    logic        alias_sel, alias_hi;
    logic        hit, wr_en;
    logic [31:0] rd_val, wval;
    logic [63:0] cnt_val;
    logic [63:0] mcycle, minstret;
    logic [63:0] hpm_val [MHPM_MAX_NUM];
    logic [EventWidth-1:0] mhpmevent [MHPM_MAX_NUM];
    logic [31:0] inhibit_q;

    // All counter groups are 32-aligned, and the low 5 address bits equal the inhibit bit index.
    assign addr    = csr_addr_i;
    assign sub     = addr[4:0];
    assign sub_hpm = (sub >= 5'(HPM_FIRST_IDX)) && (sub < 5'(HPM_FIRST_IDX + MHPM_MAX_NUM));
    assign sub_cnt = (sub == 5'(CSR_MCOUNTINHIBIT_CY_BIT)) ||
                     (sub == 5'(CSR_MCOUNTINHIBIT_IR_BIT)) || sub_hpm;
    assign hpm_idx = sub_hpm ? 4'(sub - 5'(HPM_FIRST_IDX)) : '0;

    assign inh_sel = (addr == CSR_MCOUNTINHIBIT);
    assign ev_sel  = (addr >= CSR_MHPMEVENT3) && (addr <= CSR_MHPMEVENT12);
    assign lo_sel  = (addr >= CSR_MCYCLE) && (addr <= CSR_MHPMCOUNTER12) && sub_cnt;
    assign hi_sel  = (addr >= CSR_MCYCLEH) && (addr <= CSR_MHPMCOUNTER12H) && sub_cnt;

`ifdef CVE2_HPM_USER_ALIAS_EN
    assign alias_hi  = (addr == CSR_CYCLEH) || (addr == CSR_INSTRETH);
    assign alias_sel = alias_hi || (addr == CSR_CYCLE) || (addr == CSR_INSTRET);
`else
    assign alias_hi  = 1'b0;
    assign alias_sel = 1'b0;
`endif

    always_comb begin
        cnt_val = '0;
        if (sub == 5'(CSR_MCOUNTINHIBIT_CY_BIT))      cnt_val = mcycle;
        else if (sub == 5'(CSR_MCOUNTINHIBIT_IR_BIT)) cnt_val = minstret;
        else if (sub_hpm)                             cnt_val = hpm_val[hpm_idx];

        rd_val = '0;
        if (inh_sel)                                rd_val = inhibit_q;
        else if (ev_sel)                            rd_val = 32'(mhpmevent[hpm_idx]);
        else if (lo_sel || (alias_sel && !alias_hi)) rd_val = cnt_val[31:0];
        else if (hi_sel || alias_sel)               rd_val = cnt_val[63:32];

        unique case (csr_op_i)
            CSR_OP_WRITE: wval = csr_wdata_i;
            CSR_OP_SET:   wval = rd_val | csr_wdata_i;
            CSR_OP_CLEAR: wval = rd_val & ~csr_wdata_i;
            default:      wval = rd_val;
        endcase
    end

    assign hit           = inh_sel || ev_sel || lo_sel || hi_sel || alias_sel;
    assign csr_hit_o     = csr_access_i && hit;
    assign csr_rdata_o   = csr_hit_o ? rd_val : '0;
    assign csr_illegal_o = csr_access_i && alias_sel && (csr_op_i != CSR_OP_READ);
    // Alias addresses never match any write select, so an illegal alias write cannot land.
    assign wr_en         = csr_access_i && (csr_op_i != CSR_OP_READ);

    always_ff @(posedge clk_i) begin
        if (!rst_ni)                inhibit_q <= '0;
        else if (wr_en && inh_sel)  inhibit_q <= wval & InhibitMask;
    end

    cve2_counter #(.CounterWidth(64)) u_mcycle (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .incr   (!inhibit_q[CSR_MCOUNTINHIBIT_CY_BIT]),
        .we_lo  (wr_en && lo_sel && (sub == 5'(CSR_MCOUNTINHIBIT_CY_BIT))),
        .we_hi  (wr_en && hi_sel && (sub == 5'(CSR_MCOUNTINHIBIT_CY_BIT))),
        .wdata  ({wval, wval}),
        .value  (mcycle)
    );

    cve2_counter #(.CounterWidth(64)) u_minstret (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .incr   (instr_ret_i && !inhibit_q[CSR_MCOUNTINHIBIT_IR_BIT]),
        .we_lo  (wr_en && lo_sel && (sub == 5'(CSR_MCOUNTINHIBIT_IR_BIT))),
        .we_hi  (wr_en && hi_sel && (sub == 5'(CSR_MCOUNTINHIBIT_IR_BIT))),
        .wdata  ({wval, wval}),
        .value  (minstret)
    );

    for (genvar i = 0; i < MHPM_MAX_NUM; i++) begin : g_hpm
        if (i < MHPMCounterNum) begin : g_impl
            logic [EventWidth-1:0]       event_q;
            logic [MHPMCounterWidth-1:0] value;

            always_ff @(posedge clk_i) begin
                if (!rst_ni)                                     event_q <= '0;
                else if (wr_en && ev_sel && (hpm_idx == 4'(i)))  event_q <= wval[EventWidth-1:0];
            end

            cve2_counter #(.CounterWidth(MHPMCounterWidth)) u_cnt (
                .clk_i  (clk_i),
                .rst_ni (rst_ni),
                .incr   ((|(event_q & hpm_event_i)) && !inhibit_q[HPM_FIRST_IDX + i]),
                .we_lo  (wr_en && lo_sel && (sub == 5'(HPM_FIRST_IDX + i))),
                .we_hi  (wr_en && hi_sel && (sub == 5'(HPM_FIRST_IDX + i))),
                .wdata  (MHPMCounterWidth'({wval, wval})),
                .value  (value)
            );

            assign mhpmevent[i] = event_q;
            assign hpm_val[i]   = 64'(value);
        end else begin : g_unimpl
            assign mhpmevent[i] = '0;
            assign hpm_val[i]   = '0;
        end
    end

endmodule

// File: tb/tb_cve2_hpm_unit.sv
// Scoreboard bench for cve2_hpm_unit; alias checks follow CVE2_HPM_USER_ALIAS_EN.
module tb_cve2_hpm_unit;
    import cve2_pkg::*;

`ifdef CVE2_HPM_USER_ALIAS_EN
    localparam bit ALIAS = 1'b1;
`else
    localparam bit ALIAS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        instr_ret = 1'b0;
    logic [15:0] hpm_event = '0;
    logic        csr_access = 1'b0;
    csr_num_e    csr_addr = CSR_MCYCLE;
    csr_op_e     csr_op = CSR_OP_READ;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata;
    logic        csr_hit;
    logic        csr_illegal;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [31:0] exp_rd_q [$];
    logic [2:0]  exp_flag_q [$];
    string       name_q [$];

    always #5 clk = ~clk;

    cve2_hpm_unit #(
        .MHPMCounterNum   (2),
        .MHPMCounterWidth (40),
        .EventWidth       (16)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .instr_ret_i   (instr_ret),
        .hpm_event_i   (hpm_event),
        .csr_access_i  (csr_access),
        .csr_addr_i    (csr_addr),
        .csr_op_i      (csr_op),
        .csr_wdata_i   (csr_wdata),
        .csr_rdata_o   (csr_rdata),
        .csr_hit_o     (csr_hit),
        .csr_illegal_o (csr_illegal)
    );

    // Monitor: every access cycle pops one expectation, sampled mid-cycle.
    always @(negedge clk) begin
        if (csr_access) begin
            n_cmp++;
            if (exp_rd_q.size() == 0) begin
                n_bad++;
                $display("FAIL unqueued_access: addr=%h has no expectation", csr_addr);
            end else begin
                logic [31:0] er;
                logic [2:0]  ef;
                string       nm;
                er = exp_rd_q.pop_front();
                ef = exp_flag_q.pop_front();
                nm = name_q.pop_front();
                if (csr_hit !== ef[1] || csr_illegal !== ef[0] || (ef[2] && csr_rdata !== er)) begin
                    n_bad++;
                    $display("FAIL %s: got rdata=%h hit=%b illegal=%b, expected rdata=%h hit=%b illegal=%b",
                             nm, csr_rdata, csr_hit, csr_illegal, er, ef[1], ef[0]);
                end
            end
        end
    end

    task automatic csr(input csr_op_e op, input csr_num_e a, input logic [31:0] wd,
                       input logic [31:0] er, input logic chk, input logic eh,
                       input logic ei, input string nm);
        csr_access = 1'b1;
        csr_op     = op;
        csr_addr   = a;
        csr_wdata  = wd;
        exp_rd_q.push_back(er);
        exp_flag_q.push_back({chk, eh, ei});
        name_q.push_back(nm);
        @(posedge clk); #1;
        csr_access = 1'b0;
        csr_op     = CSR_OP_READ;
        csr_wdata  = '0;
    endtask

    task automatic rd(input csr_num_e a, input logic [31:0] er, input string nm);
        csr(CSR_OP_READ, a, 32'h0, er, 1'b1, 1'b1, 1'b0, nm);
    endtask

    task automatic wr(input csr_op_e op, input csr_num_e a, input logic [31:0] wd,
                      input logic [31:0] er, input string nm);
        csr(op, a, wd, er, 1'b1, 1'b1, 1'b0, nm);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse(input logic [15:0] ev);
        hpm_event = ev;
        ticks(1);
        hpm_event = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ticks(2);
        rd(CSR_MCYCLE, 32'h0, "reset_mcycle");
        rst_ni = 1'b1;

        ticks(10);
        rd(CSR_MCYCLE,   32'd10, "mcycle_after_10");
        rd(CSR_MINSTRET, 32'd0,  "minstret_idle");
        rd(CSR_MCYCLEH,  32'd0,  "mcycleh_idle");

        wr(CSR_OP_WRITE, CSR_MCYCLE,  32'hFFFF_FFFF, 32'd13, "wr_mcycle_prev");
        wr(CSR_OP_WRITE, CSR_MCYCLEH, 32'h0,         32'd0,  "wr_mcycleh_prev");
        ticks(1);
        rd(CSR_MCYCLE,  32'h0, "mcycle_carry_lo");
        rd(CSR_MCYCLEH, 32'h1, "mcycle_carry_hi");

        instr_ret = 1'b1;
        wr(CSR_OP_WRITE, CSR_MINSTRET, 32'h55, 32'h0, "wr_minstret_prev");
        instr_ret = 1'b0;
        rd(CSR_MINSTRET, 32'h55, "minstret_write_wins");
        instr_ret = 1'b1;
        ticks(3);
        instr_ret = 1'b0;
        rd(CSR_MINSTRET, 32'h58, "minstret_count3");
        wr(CSR_OP_SET,   CSR_MINSTRET, 32'h100, 32'h58,  "set_minstret_prev");
        rd(CSR_MINSTRET, 32'h158, "minstret_after_set");
        wr(CSR_OP_CLEAR, CSR_MINSTRET, 32'h8,   32'h158, "clr_minstret_prev");
        rd(CSR_MINSTRET, 32'h150, "minstret_after_clr");
        wr(CSR_OP_WRITE, CSR_MINSTRETH, 32'h3,  32'h0,   "wr_minstreth_prev");
        rd(CSR_MINSTRET,  32'h150, "minstret_lo_kept");
        rd(CSR_MINSTRETH, 32'h3,   "minstret_hi_written");

        wr(CSR_OP_WRITE, CSR_MCOUNTINHIBIT, 32'hFFFF_FFFF, 32'h0, "wr_inhibit_prev");
        rd(CSR_MCOUNTINHIBIT, 32'h1D, "inhibit_mask");
        csr(CSR_OP_WRITE, CSR_MCYCLE, 32'h1234, 32'h0, 1'b0, 1'b1, 1'b0, "wr_mcycle_frozen");
        instr_ret = 1'b1;
        ticks(2);
        instr_ret = 1'b0;
        rd(CSR_MINSTRET, 32'h150,  "minstret_inhibited");
        rd(CSR_MCYCLE,   32'h1234, "mcycle_inhibited");

        csr(CSR_OP_READ,  CSR_CYCLE, 32'h0, ALIAS ? 32'h1234 : 32'h0, 1'b1, ALIAS, 1'b0, "alias_cycle_read");
        csr(CSR_OP_WRITE, CSR_CYCLE, 32'h5, ALIAS ? 32'h1234 : 32'h0, 1'b1, ALIAS, ALIAS, "alias_cycle_write");
        rd(CSR_MCYCLE, 32'h1234, "mcycle_after_alias_write");
        csr(CSR_OP_READ, CSR_INSTRETH, 32'h0, ALIAS ? 32'h3 : 32'h0, 1'b1, ALIAS, 1'b0, "alias_instreth_read");

        wr(CSR_OP_CLEAR, CSR_MCOUNTINHIBIT, 32'h1D, 32'h1D, "clr_inhibit_prev");
        rd(CSR_MCOUNTINHIBIT, 32'h0, "inhibit_cleared");

        wr(CSR_OP_WRITE, CSR_MHPMEVENT3, 32'hFFFF_0004, 32'h0, "wr_event3_prev");
        rd(CSR_MHPMEVENT3, 32'h4, "event3_width_trunc");
        pulse(16'hFFFB);
        pulse(16'h0004);
        ticks(1);
        pulse(16'h0004);
        wr(CSR_OP_SET, CSR_MCOUNTINHIBIT, 32'h8, 32'h0, "set_inhibit3_prev");
        pulse(16'h0004);
        rd(CSR_MHPMCOUNTER3,  32'h2, "hpm3_two_events");
        rd(CSR_MCOUNTINHIBIT, 32'h8, "inhibit_bit3");

        wr(CSR_OP_WRITE, CSR_MHPMEVENT4, 32'h3, 32'h0, "wr_event4_prev");
        pulse(16'hFFFF);
        rd(CSR_MHPMCOUNTER4, 32'h1, "hpm4_single_incr");
        rd(CSR_MHPMCOUNTER3, 32'h2, "hpm3_still_inhibited");

        wr(CSR_OP_WRITE, CSR_MHPMCOUNTER3H, 32'hFFFF_FFFF, 32'h0, "wr_hpm3h_prev");
        rd(CSR_MHPMCOUNTER3H, 32'hFF, "hpm3h_zero_ext");
        rd(CSR_MHPMCOUNTER3,  32'h2,  "hpm3_lo_kept");
        wr(CSR_OP_WRITE, CSR_MHPMCOUNTER3, 32'hFFFF_FFFF, 32'h2, "wr_hpm3_prev");
        wr(CSR_OP_CLEAR, CSR_MCOUNTINHIBIT, 32'h8, 32'h8, "clr_inhibit3_prev");
        pulse(16'h0004);
        rd(CSR_MHPMCOUNTER3,  32'h0, "hpm3_wrap_lo");
        rd(CSR_MHPMCOUNTER3H, 32'h0, "hpm3_wrap_hi");

        wr(CSR_OP_WRITE, CSR_MHPMCOUNTER12H, 32'hFFFF_FFFF, 32'h0, "wr_hpm12h_unimpl");
        rd(CSR_MHPMCOUNTER12H, 32'h0, "hpm12h_reads_zero");
        wr(CSR_OP_WRITE, CSR_MHPMEVENT12, 32'hFFFF, 32'h0, "wr_event12_unimpl");
        rd(CSR_MHPMEVENT12, 32'h0, "event12_reads_zero");
        csr(CSR_OP_WRITE, csr_num_e'(12'h300), 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b0, "unowned_addr");

        rst_ni = 1'b0;
        wr(CSR_OP_WRITE, CSR_MINSTRET, 32'h77, 32'h150, "wr_in_reset_prev");
        rd(CSR_MINSTRET,      32'h0, "rst_minstret");
        rd(CSR_MINSTRETH,     32'h0, "rst_minstreth");
        rd(CSR_MHPMCOUNTER4,  32'h0, "rst_hpm4");
        rd(CSR_MHPMEVENT3,    32'h0, "rst_event3");
        rd(CSR_MCOUNTINHIBIT, 32'h0, "rst_inhibit");
        rd(CSR_MCYCLE,        32'h0, "rst_mcycle");
        rst_ni = 1'b1;

        for (int i = 0; i < 10 && exp_rd_q.size() != 0; i++) ticks(1);
        if (exp_rd_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_rd_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
